// File: rtl/pll_lock_monitor_pkg.sv
// Shared definitions for the PLL lock monitor: FSM encoding, field widths
// and parameter defaults.
package pll_lock_monitor_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int unsigned DEF_LOCK_FILT = 16;
  localparam int unsigned DEF_LOSS_FILT = 8;
  localparam logic [23:0] DEF_TIMEOUT   = 24'd20000;
  localparam int unsigned DEF_MAX_RETRY = 3;

  localparam int TIMER_W = 24;
  localparam int FILT_W  = 8;
  localparam int RETRY_W = 2;

  typedef enum logic [2:0] {
    ST_REQ      = 3'd0,
    ST_WAIT_CFG = 3'd1,
    ST_ACQUIRE  = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

endpackage

// File: rtl/pll_lock_monitor_ld_sync.sv
// Two-flop synchroniser bringing the asynchronous lock-detect pin into the
// monitor clock domain.
module ld_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ld,
  output logic ld_s
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], ld};
    end
  end

  assign ld_s = sync_reg[1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Supervises synthesiser lock: requests reprogramming, filters the lock-detect
// pin, times out and retries acquisition, and flags loss of lock.
module pll_lock_monitor
  import pll_lock_monitor_pkg::*;
#(
  parameter int unsigned P_LOCK_FILT = DEF_LOCK_FILT,
  parameter int unsigned P_LOSS_FILT = DEF_LOSS_FILT,
  parameter logic [23:0] P_TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned P_MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_ld,
  input  logic        in_cfg_done,
  input  logic        in_rearm,
  input  logic        in_lol_clr,
  output logic        out_reinit,
  output logic        out_locked,
  output logic        out_fault,
  output logic        out_lol,
  output logic [23:0] out_lock_time,
  output logic [1:0]  out_retry_cnt
);

  localparam logic [FILT_W-1:0]  LOCK_FILT    = FILT_W'(P_LOCK_FILT);
  localparam logic [FILT_W-1:0]  LOSS_FILT    = FILT_W'(P_LOSS_FILT);
  localparam logic [RETRY_W-1:0] MAX_RETRY    = RETRY_W'(P_MAX_RETRY);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = P_TIMEOUT - 24'd1;

  logic                ld_s;
  state_t              state_reg, state_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [FILT_W-1:0]   filter_reg, filter_next, filt_inc;
  logic [RETRY_W-1:0]  retry_reg, retry_next;
  logic                lol_reg, lol_next;
  logic [TIMER_W-1:0]  lock_time_reg, lock_time_next;
  logic                reinit_reg, reinit_next;
  logic                locked_reg, locked_next;
  logic                fault_reg, fault_next;
  logic                timeout, lock_evt, loss_evt, retry_ok, acquiring;

  ld_sync u_ld_sync (
    .clk   (in_clk),
    .rst_n (in_rst_n),
    .ld    (in_ld),
    .ld_s  (ld_s)
  );

  // The filter count includes the current cycle, so "reaching" the threshold
  // is decided on the cycle that supplies the last qualifying sample.
  assign filt_inc  = filter_reg + 8'd1;
  assign acquiring = (state_reg == ST_WAIT_CFG) || (state_reg == ST_ACQUIRE);
  assign timeout   = acquiring && (timer_reg == TIMEOUT_LAST);
  assign lock_evt  = (state_reg == ST_ACQUIRE) && (ld_s == HIGH) && (filt_inc == LOCK_FILT);
  assign loss_evt  = (state_reg == ST_LOCKED) && (ld_s == LOW) && (filt_inc == LOSS_FILT) && !in_rearm;
  assign retry_ok  = (retry_reg < MAX_RETRY);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_reg <= ST_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (in_rearm) begin
      state_next = ST_REQ;
    end else begin
      case (state_reg)
        ST_REQ:      state_next = ST_WAIT_CFG;
        ST_WAIT_CFG: begin
          if (timeout)          state_next = retry_ok ? ST_REQ : ST_FAULT;
          else if (in_cfg_done) state_next = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (lock_evt)     state_next = ST_LOCKED;
          else if (timeout) state_next = retry_ok ? ST_REQ : ST_FAULT;
        end
        ST_LOCKED:   if (loss_evt) state_next = ST_REQ;
        ST_FAULT:    state_next = ST_FAULT;
        default:     state_next = ST_REQ;
      endcase
    end
  end

  // Reinit follows the REQ state by one cycle so reset never leaves a pulse.
  always_comb begin
    reinit_next = (state_reg == ST_REQ);
    locked_next = (state_next == ST_LOCKED);
    fault_next  = (state_reg == ST_FAULT);
  end

  always_comb begin
    timer_next     = timer_reg;
    filter_next    = '0;
    retry_next     = retry_reg;
    lol_next       = lol_reg;
    lock_time_next = lock_time_reg;

    case (state_reg)
      ST_REQ:      timer_next = '0;
      ST_WAIT_CFG: timer_next = timer_reg + 24'd1;
      ST_ACQUIRE: begin
        timer_next  = timer_reg + 24'd1;
        filter_next = ((ld_s == HIGH) && !lock_evt) ? filt_inc : '0;
      end
      ST_LOCKED:   filter_next = ((ld_s == LOW) && !loss_evt) ? filt_inc : '0;
      default:     filter_next = '0;
    endcase

    if (lock_evt && !in_rearm) lock_time_next = timer_reg + 24'd1;

    if (in_rearm || loss_evt)                  retry_next = '0;
    else if (acquiring && state_next == ST_REQ) retry_next = retry_reg + 2'd1;

    if (loss_evt)        lol_next = 1'b1;
    else if (in_lol_clr) lol_next = 1'b0;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      timer_reg     <= '0;
      filter_reg    <= '0;
      retry_reg     <= '0;
      lol_reg       <= 1'b0;
      lock_time_reg <= '0;
      reinit_reg    <= 1'b0;
      locked_reg    <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      timer_reg     <= timer_next;
      filter_reg    <= filter_next;
      retry_reg     <= retry_next;
      lol_reg       <= lol_next;
      lock_time_reg <= lock_time_next;
      reinit_reg    <= reinit_next;
      locked_reg    <= locked_next;
      fault_reg     <= fault_next;
    end
  end

  assign out_reinit    = reinit_reg;
  assign out_locked    = locked_reg;
  assign out_fault     = fault_reg;
  assign out_lol       = lol_reg;
  assign out_lock_time = lock_time_reg;
  assign out_retry_cnt = retry_reg;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: lock, loss, sticky flag, timeout/retry
// to fault, rearm and mid-operation reset, with hand-computed cycle numbers.
module tb_pll_lock_monitor;

  logic        clk = 1'b0;
  logic        in_rst_n, in_ld, in_cfg_done, in_rearm, in_lol_clr;
  logic        out_reinit, out_locked, out_fault, out_lol;
  logic [23:0] out_lock_time;
  logic [1:0]  out_retry_cnt;

  int cyc;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .P_LOCK_FILT (4),
    .P_LOSS_FILT (4),
    .P_TIMEOUT   (24'd100),
    .P_MAX_RETRY (2)
  ) dut (
    .in_clk        (clk),
    .in_rst_n      (in_rst_n),
    .in_ld         (in_ld),
    .in_cfg_done   (in_cfg_done),
    .in_rearm      (in_rearm),
    .in_lol_clr    (in_lol_clr),
    .out_reinit    (out_reinit),
    .out_locked    (out_locked),
    .out_fault     (out_fault),
    .out_lol       (out_lol),
    .out_lock_time (out_lock_time),
    .out_retry_cnt (out_retry_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end else begin
      $display("ok   %s cycle %0d: %0d", tag, cyc, got);
    end
  endtask

  // Cycle k is the interval after the k-th rising edge following reset release.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_reset();
    in_rst_n    = 1'b0;
    in_ld       = 1'b0;
    in_cfg_done = 1'b0;
    in_rearm    = 1'b0;
    in_lol_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_rst_n = 1'b1;
    cyc      = 0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    logic saw_lock;

    cyc         = 0;
    in_rst_n    = 1'b0;
    in_ld       = 1'b0;
    in_cfg_done = 1'b0;
    in_rearm    = 1'b0;
    in_lol_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_reinit", 32'(out_reinit), 0);
    check_eq("rst_locked", 32'(out_locked), 0);
    check_eq("rst_fault", 32'(out_fault), 0);
    check_eq("rst_lol", 32'(out_lol), 0);
    check_eq("rst_lock_time", 32'(out_lock_time), 0);
    check_eq("rst_retry", 32'(out_retry_cnt), 0);
    in_rst_n = 1'b1;
    cyc      = 0;

    // Acquisition: cfg_done in cycle 5, lock-detect high from cycle 10.
    tick();
    check_eq("first_reinit", 32'(out_reinit), 1);
    tick();
    check_eq("reinit_one_cycle", 32'(out_reinit), 0);
    step_to(5);
    in_cfg_done = 1'b1;
    tick();
    in_cfg_done = 1'b0;
    step_to(10);
    in_ld = 1'b1;
    step_to(15);
    check_eq("not_yet_locked", 32'(out_locked), 0);
    tick();
    check_eq("locked_rise", 32'(out_locked), 1);
    check_eq("lock_time", 32'(out_lock_time), 15);

    // Three low cycles are tolerated, four declare loss.
    step_to(20);
    in_ld = 1'b0;
    step_to(23);
    in_ld = 1'b1;
    step_to(28);
    check_eq("glitch_keeps_lock", 32'(out_locked), 1);
    check_eq("glitch_no_lol", 32'(out_lol), 0);
    step_to(30);
    in_ld = 1'b0;
    step_to(35);
    check_eq("loss_pending", 32'(out_locked), 1);
    in_lol_clr = 1'b1;
    tick();
    in_lol_clr = 1'b0;
    check_eq("loss_beats_clr", 32'(out_lol), 1);
    check_eq("loss_unlocked", 32'(out_locked), 0);
    check_eq("loss_retry", 32'(out_retry_cnt), 0);
    tick();
    check_eq("loss_reinit", 32'(out_reinit), 1);
    step_to(40);
    check_eq("lol_sticky", 32'(out_lol), 1);
    in_lol_clr  = 1'b1;
    in_cfg_done = 1'b1;
    tick();
    in_lol_clr  = 1'b0;
    in_cfg_done = 1'b0;
    check_eq("lol_cleared", 32'(out_lol), 0);

    // Reset while acquiring clears everything without waiting for an edge.
    step_to(45);
    in_rst_n = 1'b0;
    #1;
    check_eq("async_lock_time", 32'(out_lock_time), 0);
    check_eq("async_reinit", 32'(out_reinit), 0);
    check_eq("async_locked", 32'(out_locked), 0);
    check_eq("async_retry", 32'(out_retry_cnt), 0);

    // Mode 0: lock-detect stuck low. Mode 1: lock-detect toggling every 3 cycles.
    for (int m = 0; m < 2; m++) begin
      do_reset();
      pulses   = 0;
      saw_lock = 1'b0;
      for (int k = 1; k <= 304; k++) begin
        tick();
        if (out_reinit) pulses++;
        if (out_locked) saw_lock = 1'b1;
        if (cyc == 1 || cyc == 102 || cyc == 203)
          check_eq($sformatf("m%0d_reinit", m), 32'(out_reinit), 1);
        if (cyc == 102) check_eq($sformatf("m%0d_retry1", m), 32'(out_retry_cnt), 1);
        if (cyc == 303) check_eq($sformatf("m%0d_fault_early", m), 32'(out_fault), 0);
        if (cyc == 304) begin
          check_eq($sformatf("m%0d_fault", m), 32'(out_fault), 1);
          check_eq($sformatf("m%0d_retry2", m), 32'(out_retry_cnt), 2);
        end
        in_ld       = (m == 1) ? (((cyc / 3) % 2) == 1) : 1'b0;
        in_cfg_done = (m == 1) && (cyc == 5 || cyc == 110 || cyc == 210);
      end
      check_eq($sformatf("m%0d_pulse_count", m), 32'(pulses), 3);
      check_eq($sformatf("m%0d_never_locked", m), 32'(saw_lock), 0);

      step_to(310);
      check_eq($sformatf("m%0d_fault_hold", m), 32'(out_fault), 1);
      in_rearm = 1'b1;
      tick();
      in_rearm = 1'b0;
      check_eq($sformatf("m%0d_rearm_retry", m), 32'(out_retry_cnt), 0);
      tick();
      check_eq($sformatf("m%0d_rearm_reinit", m), 32'(out_reinit), 1);
      check_eq($sformatf("m%0d_rearm_fault", m), 32'(out_fault), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter P_LOCK_FILT, default 16: consecutive synchronised lock-detect-high cycles needed to declare lock (range 1-255).
REQ-002 SHALL have parameter P_LOSS_FILT, default 8: consecutive synchronised lock-detect-low cycles needed to declare loss of lock (range 1-255).
REQ-003 SHALL have parameter P_TIMEOUT, default 24'd20000: cycles allowed from the reinit pulse to lock (range 1 to 2^24-1).
REQ-004 SHALL have parameter P_MAX_RETRY, default 3: reinit retries allowed after the first attempt before fault (range 0-3).
REQ-005 SHALL have port in_clk, input, 1 bit: the single clock; every flop is in this domain.
REQ-006 SHALL have port in_rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port in_ld, input, 1 bit: ADF4360 lock-detect pin, asynchronous to in_clk.
REQ-008 SHALL have port in_cfg_done, input, 1 bit: one-cycle pulse from the synthesiser configuration block when the N-counter word has been latched.
REQ-009 SHALL have port in_rearm, input, 1 bit: one-cycle host pulse that restarts acquisition with the retry count cleared.
REQ-010 SHALL have port in_lol_clr, input, 1 bit: one-cycle host pulse that clears out_lol.
REQ-011 SHALL have port out_reinit, output, 1 bit: one-cycle request to the configuration block to reprogram the synthesiser.
REQ-012 SHALL have port out_locked, output, 1 bit: high only in ST_LOCKED.
REQ-013 SHALL have port out_fault, output, 1 bit: high only in ST_FAULT.
REQ-014 SHALL have port out_lol, output, 1 bit: sticky loss-of-lock flag.
REQ-015 SHALL have port out_lock_time, output, 24 bits: cycle count from the last reinit pulse to the last lock declaration.
REQ-016 SHALL have port out_retry_cnt, output, 2 bits: retries consumed in the current episode.

Function
REQ-017 SHALL pass in_ld through a 2-flop synchroniser (ld_s); ld_s lags in_ld by 2 cycles, and the FSM uses only ld_s.
REQ-018 SHALL implement FSM states ST_REQ, ST_WAIT_CFG, ST_ACQUIRE, ST_LOCKED and ST_FAULT.
REQ-019 ST_REQ SHALL drive out_reinit=1 for exactly one cycle, clear the timer and the filter counter, and go to ST_WAIT_CFG next cycle.
REQ-020 ST_WAIT_CFG SHALL go to ST_ACQUIRE on in_cfg_done; in_cfg_done SHALL be ignored in every other state.
REQ-021 A 24-bit timer SHALL increment every cycle in ST_WAIT_CFG and ST_ACQUIRE.
REQ-022 When timer == P_TIMEOUT-1 in ST_WAIT_CFG or ST_ACQUIRE, the FSM SHALL go to ST_REQ and increment retry_cnt if retry_cnt < P_MAX_RETRY, else go to ST_FAULT.
REQ-023 In ST_ACQUIRE the filter counter SHALL increment while ld_s=1 and clear when ld_s=0.
REQ-024 When the filter reaches P_LOCK_FILT in ST_ACQUIRE, the FSM SHALL enter ST_LOCKED next cycle and load out_lock_time with timer+1.
REQ-025 Lock SHALL take priority over timeout when both occur in the same cycle.
REQ-026 In ST_LOCKED the filter SHALL count consecutive ld_s=0 cycles; on reaching P_LOSS_FILT the block SHALL set out_lol, clear retry_cnt and go to ST_REQ.
REQ-027 ST_FAULT SHALL hold until in_rearm.
REQ-028 in_rearm in any state SHALL force ST_REQ next cycle with retry_cnt=0 and SHALL win over a simultaneous timeout, lock or loss event.
REQ-029 in_lol_clr SHALL clear out_lol; a loss event in the same cycle SHALL win and leave out_lol=1.
REQ-030 out_reinit, out_locked and out_fault SHALL be registered, with no combinational path from any input.

Reset
REQ-031 While in_rst_n=0: state ST_REQ with out_reinit held 0, synchroniser flops=0, timer=0, filter=0, retry_cnt=0, out_locked=0, out_fault=0, out_lol=0, out_lock_time=0.
REQ-032 The first out_reinit pulse SHALL occur in the first cycle after in_rst_n deasserts.
REQ-033 Reset asserted mid-operation SHALL abort immediately with no trailing out_reinit pulse.

Structure
REQ-034 State encodings and parameter defaults SHALL live in the shared globals include alongside the existing HIGH/LOW defines.
REQ-035 The synchroniser SHALL be a sub-module named ld_sync (2 flops, async active-low reset); all other logic stays in pll_lock_monitor.

Verification (bench parameters: P_LOCK_FILT=4, P_LOSS_FILT=4, P_TIMEOUT=100, P_MAX_RETRY=2)
REQ-036 Reset release, in_cfg_done at cycle 5, in_ld high from cycle 10 -> out_reinit pulse at cycle 1, out_locked rises at cycle 16, out_lock_time=15.
REQ-037 in_ld never high -> out_reinit pulses at cycles 1, 102 and 203, then out_fault=1 from cycle 304 with out_retry_cnt=2; in_rearm -> out_reinit next cycle with out_retry_cnt=0.
REQ-038 Locked, then in_ld low for 3 cycles -> out_locked stays 1; in_ld low for 4 or more cycles -> out_lol=1, out_locked=0, then out_reinit pulses.
REQ-039 in_lol_clr in the same cycle as a loss event -> out_lol=1; in_lol_clr alone later -> out_lol=0.
REQ-040 in_ld toggling every 3 cycles during ST_ACQUIRE -> no lock, timeout and retry as in REQ-037.
REQ-041 in_rst_n asserted in ST_ACQUIRE -> all outputs 0 immediately; after release, a single out_reinit pulse.
